// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider, signed or unsigned.
// An accepted request spends WIDTH cycles in CALC, one bit per edge. The
// final CALC edge also applies the result signs and writes the outputs.
// The divider then spends one cycle in SIGN with done high. A new request
// may be accepted in SIGN, so divisions can be issued back to back every
// WIDTH+1 cycles. Latency does not depend on the operand values.
module div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src0,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ov,
  output logic             zr,
  output logic             neg
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Two's-complement negation.
  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;      // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_prem;     // partial remainder magnitude
  logic [WIDTH-1:0] r_div;      // divisor magnitude
  logic [WIDTH-1:0] r_src1;     // original dividend, returned as remainder on divide-by-zero
  logic             r_sgn;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_is_dz;
  logic             r_is_ov;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_done;
  logic             r_dz;
  logic             r_ov;
  logic             r_zr;
  logic             r_neg;

  logic             w_accept;
  logic             w_last;
  logic             w_src1_neg;
  logic             w_src0_neg;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag0;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_new_prem;
  logic [WIDTH-1:0] w_new_quo;
  logic [WIDTH-1:0] w_qfin;
  logic [WIDTH-1:0] w_rfin;

  // A request is taken when idle, or in the SIGN cycle, which allows
  // back-to-back issue.
  assign w_accept   = start & ((r_state == IDLE) | (r_state == SIGN));
  assign w_last     = (r_state == CALC) & (r_cnt == CW'(WIDTH - 1));
  assign w_src1_neg = sgn & src1[WIDTH-1];
  assign w_src0_neg = sgn & src0[WIDTH-1];
  assign w_mag1     = w_src1_neg ? twos_neg(src1) : src1;
  assign w_mag0     = w_src0_neg ? twos_neg(src0) : src0;

  // One restoring step: shift in the next dividend bit, then subtract the
  // divisor when the shifted value is large enough.
  assign w_shift    = {r_prem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_new_quo  = {r_quo[WIDTH-2:0], w_ge};

  // Select the partial remainder that the restoring step keeps.
  always_comb begin
    w_new_prem = w_shift[WIDTH-1:0];
    if (w_ge) begin
      w_new_prem = w_diff[WIDTH-1:0];
    end else begin
      w_new_prem = w_shift[WIDTH-1:0];
    end
  end

  // Apply result signs and the divide-by-zero and overflow overrides to the
  // last step's magnitudes.
  always_comb begin
    w_qfin = w_new_quo;
    w_rfin = w_new_prem;
    if (r_is_dz) begin
      w_rfin = r_src1;
      if (r_sgn) begin
        if (r_rneg) begin
          w_qfin = MIN_NEG;
        end else begin
          w_qfin = MAX_POS;
        end
      end else begin
        w_qfin = ALL_ONES;
      end
    end else if (r_is_ov) begin
      w_qfin = MAX_POS;
      w_rfin = ZERO;
    end else begin
      if (r_qneg) begin
        w_qfin = twos_neg(w_new_quo);
      end else begin
        w_qfin = w_new_quo;
      end
      if (r_rneg) begin
        w_rfin = twos_neg(w_new_prem);
      end else begin
        w_rfin = w_new_prem;
      end
    end
  end

  // Register the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Compute the next FSM state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = CALC;
        end else begin
          w_next = IDLE;
        end
      end
      CALC: begin
        if (w_last) begin
          w_next = SIGN;
        end else begin
          w_next = CALC;
        end
      end
      SIGN: begin
        if (w_accept) begin
          w_next = CALC;
        end else begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Datapath: capture operands, iterate, and write the results on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= {CW{1'b0}};
      r_quo   <= ZERO;
      r_prem  <= ZERO;
      r_div   <= ZERO;
      r_src1  <= ZERO;
      r_sgn   <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_is_dz <= 1'b0;
      r_is_ov <= 1'b0;
      r_quot  <= ZERO;
      r_rem   <= ZERO;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_ov    <= 1'b0;
      r_zr    <= 1'b1;
      r_neg   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt   <= {CW{1'b0}};
        r_quo   <= w_mag1;
        r_prem  <= ZERO;
        r_div   <= w_mag0;
        r_src1  <= src1;
        r_sgn   <= sgn;
        r_qneg  <= w_src1_neg ^ w_src0_neg;
        r_rneg  <= w_src1_neg;
        r_is_dz <= (src0 == ZERO);
        r_is_ov <= sgn & (src1 == MIN_NEG) & (src0 == ALL_ONES);
      end else if (r_state == CALC) begin
        r_cnt  <= r_cnt + CW'(1);
        r_quo  <= w_new_quo;
        r_prem <= w_new_prem;
        if (w_last) begin
          r_quot <= w_qfin;
          r_rem  <= w_rfin;
          r_dz   <= r_is_dz;
          r_ov   <= r_is_ov;
          r_zr   <= ~|w_qfin;
          r_neg  <= w_qfin[WIDTH-1];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign quot = r_quot;
  assign rem  = r_rem;
  assign dz   = r_dz;
  assign ov   = r_ov;
  assign zr   = r_zr;
  assign neg  = r_neg;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed, self-checking bench for div_unit (WIDTH=16).
module tb_div_unit;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] src1;
  logic [W-1:0] src0;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         busy;
  logic         done;
  logic         dz;
  logic         ov;
  logic         zr;
  logic         neg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } vec_t;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .src1(src1), .src0(src0),
    .quot(quot), .rem(rem), .busy(busy), .done(done),
    .dz(dz), .ov(ov), .zr(zr), .neg(neg)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait for done. lat counts cycles from the accept
  // cycle to the done cycle; bcnt counts cycles with busy high. Operands
  // are scrambled while busy.
  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    sgn = s; src1 = a; src0 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sgn = ~s; src1 = W'($urandom); src0 = W'($urandom);
    bcnt = busy ? 1 : 0;
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src0 = '0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (quot !== 16'h0000) begin errors++; $display("FAIL reset_quot got %h want 0000", quot); end
    checks++; if (rem !== 16'h0000) begin errors++; $display("FAIL reset_rem got %h want 0000", rem); end
    checks++; if ({dz, ov, zr, neg} !== 4'b0010) begin errors++; $display("FAIL reset_flags got %b want 0010", {dz, ov, zr, neg}); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_unsigned_basic();
    int lat, bcnt;
    run_op(1'b0, 16'h00C8, 16'h0007, lat, bcnt);
    checks++; if (lat !== 17) begin errors++; $display("FAIL u_latency got %0d want 17", lat); end
    checks++; if (bcnt !== 17) begin errors++; $display("FAIL u_busy_cycles got %0d want 17", bcnt); end
    checks++; if (quot !== 16'h001C) begin errors++; $display("FAIL u_quot got %h want 001c", quot); end
    checks++; if (rem !== 16'h0004) begin errors++; $display("FAIL u_rem got %h want 0004", rem); end
    checks++; if ({dz, ov, zr, neg} !== 4'b0000) begin errors++; $display("FAIL u_flags got %b want 0000", {dz, ov, zr, neg}); end
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL u_after_done busy/done got %b want 00", {busy, done}); end
    checks++; if (quot !== 16'h001C) begin errors++; $display("FAIL u_hold_quot got %h want 001c", quot); end
  endtask

  task automatic test_vectors();
    vec_t tv[12];
    int lat, bcnt;
    tv[0]  = '{1'b0, 16'h00C8, 16'h0007, 16'h001C, 16'h0004, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1};
    tv[3]  = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 16'hF000, 16'h0000, 16'h8000, 16'hF000, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 16'h1234, 16'h0000, 16'h7FFF, 16'h1234, 1'b1, 1'b0};
    tv[10] = '{1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0};
    tv[11] = '{1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      run_op(tv[i].s, tv[i].a, tv[i].b, lat, bcnt);
      checks++; if (lat !== 17) begin errors++; $display("FAIL vec%0d_latency got %0d want 17", i, lat); end
      checks++; if (quot !== tv[i].q) begin errors++; $display("FAIL vec%0d_quot got %h want %h", i, quot, tv[i].q); end
      checks++; if (rem !== tv[i].r) begin errors++; $display("FAIL vec%0d_rem got %h want %h", i, rem, tv[i].r); end
      checks++; if ({dz, ov} !== {tv[i].dz, tv[i].ov}) begin errors++; $display("FAIL vec%0d_dz_ov got %b want %b", i, {dz, ov}, {tv[i].dz, tv[i].ov}); end
      checks++; if ({zr, neg} !== {(tv[i].q == 16'h0000), tv[i].q[15]}) begin
        errors++; $display("FAIL vec%0d_zr_neg got %b want %b", i, {zr, neg}, {(tv[i].q == 16'h0000), tv[i].q[15]});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    vec_t tv[3];
    int lat;
    tv[0] = '{1'b0, 16'h00C8, 16'h0007, 16'h001C, 16'h0004, 1'b0, 1'b0};
    tv[1] = '{1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
    tv[2] = '{1'b1, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b0, 1'b1};
    @(negedge clk);
    start = 1'b1; sgn = tv[0].s; src1 = tv[0].a; src0 = tv[0].b;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b%0d_accept busy got %b want 1", i, busy); end
      sgn = ~tv[i].s; src1 = W'($urandom); src0 = W'($urandom);
      lat = 99;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (done) begin
          lat = k + 1;
          break;
        end
      end
      checks++; if (lat !== 17) begin errors++; $display("FAIL b2b%0d_latency got %0d want 17", i, lat); end
      checks++; if (quot !== tv[i].q) begin errors++; $display("FAIL b2b%0d_quot got %h want %h", i, quot, tv[i].q); end
      checks++; if (rem !== tv[i].r) begin errors++; $display("FAIL b2b%0d_rem got %h want %h", i, rem, tv[i].r); end
      checks++; if (ov !== tv[i].ov) begin errors++; $display("FAIL b2b%0d_ov got %b want %b", i, ov, tv[i].ov); end
      if (i < 2) begin
        sgn = tv[i+1].s; src1 = tv[i+1].a; src0 = tv[i+1].b;
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL b2b_end busy/done got %b want 00", {busy, done}); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, ndone;
    @(negedge clk);
    sgn = 1'b0; src1 = 16'h00C8; src0 = 16'h0007; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rmid_busy_done got %b want 00", {busy, done}); end
    checks++; if (quot !== 16'h0000) begin errors++; $display("FAIL rmid_quot got %h want 0000", quot); end
    checks++; if ({dz, ov, zr, neg} !== 4'b0010) begin errors++; $display("FAIL rmid_flags got %b want 0010", {dz, ov, zr, neg}); end
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", ndone); end
    run_op(1'b0, 16'h0064, 16'h0003, lat, bcnt);
    checks++; if (lat !== 17) begin errors++; $display("FAIL rmid_latency got %0d want 17", lat); end
    checks++; if (quot !== 16'h0021) begin errors++; $display("FAIL rmid_quot_after got %h want 0021", quot); end
    checks++; if (rem !== 16'h0001) begin errors++; $display("FAIL rmid_rem_after got %h want 0001", rem); end
  endtask

  // Run all scenarios in order and print the summary.
  initial begin
    test_reset();
    test_unsigned_basic();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
